// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for the single-bus datapath. Fetches an instruction
// (T0-T2), then steps operand reads, the ALU operation and writeback (T3-T6).
// Every datapath enable/select is a Moore decode of the state register and
// IR_Data. The only exception is MDR_enable, which follows mem_ready in T1.
//
// Optional feature: define CU_MEM_TIMEOUT_EN to add a T1 read-wait watchdog.
// The watchdog halts the sequencer and raises mem_timeout after MEM_WAIT_MAX
// cycles without mem_ready.
//
// Ports:
//   clk             system clock, rising edge
//   clr             asynchronous active-low reset
//   IR_Data         instruction register (op[31:27] Ra[26:23] Rb[22:19] Rc[18:15])
//   mem_ready       memory read data valid this cycle
//   gpr_enable      one-hot r0-r15 load enables
//   gpr_select      one-hot r0-r15 bus-source selects
//   *_enable        special register loads
//   *_select        special register bus-source selects
//   MDR_read        MDR input mux (1 = memory, 0 = bus)
//   mem_read        memory read request (address = MAR)
//   alu_instruction ALU opcode
//   halted          sequencer stopped
//   illegal_op      sticky, undefined opcode decoded
//   mem_timeout     sticky, read timed out (0 when the watchdog is not built)
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        mem_ready,
  output logic [15:0] gpr_enable,
  output logic [15:0] gpr_select,
  output logic        PC_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        PC_select,
  output logic        MDR_out_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_read,
  output logic        mem_read,
  output logic [4:0]  alu_instruction,
  output logic        halted,
  output logic        illegal_op,
  output logic        mem_timeout
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_LAST_ALU = 5'h0C;
  localparam logic [4:0] OP_MUL      = 5'h09;
  localparam logic [4:0] OP_DIV      = 5'h0A;
  localparam logic [4:0] OP_NEG      = 5'h0B;
  localparam logic [4:0] OP_NOT      = 5'h0C;
  localparam logic [4:0] OP_NOP      = 5'h18;
  localparam logic [4:0] OP_HALT     = 5'h19;

  state_t      state_r;
  state_t      state_s;
  logic        t1_wait_r;
  logic        illegal_r;
  logic        illegal_set_s;
  logic        wait_expired_s;
  logic [4:0]  opcode_s;
  logic [3:0]  ra_s;
  logic [3:0]  rb_s;
  logic [3:0]  rc_s;
  logic        is_muldiv_s;
  logic        is_unary_s;
  logic        is_legal_s;
  logic        unused_ir_s;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    reg_onehot = 16'h0001 << idx;
  endfunction

  assign opcode_s    = IR_Data[31:27];
  assign ra_s        = IR_Data[26:23];
  assign rb_s        = IR_Data[22:19];
  assign rc_s        = IR_Data[18:15];
  assign unused_ir_s = ^IR_Data[14:0];

  assign is_muldiv_s = (opcode_s == OP_MUL) || (opcode_s == OP_DIV);
  assign is_unary_s  = (opcode_s == OP_NEG) || (opcode_s == OP_NOT);
  assign is_legal_s  = (opcode_s <= OP_LAST_ALU) || (opcode_s == OP_NOP) ||
                       (opcode_s == OP_HALT);

`ifdef CU_MEM_TIMEOUT_EN
  logic [4:0] wait_cnt_r;
  logic       timeout_r;

  // Read-wait counter: held at zero outside T1, so every T1 entry starts at 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt_r <= 5'd0;
    end else if (state_r != T1) begin
      wait_cnt_r <= 5'd0;
    end else if (wait_cnt_r != 5'd31) begin
      wait_cnt_r <= wait_cnt_r + 5'd1;
    end
  end

  // Count value k means this is the (k+1)th cycle spent in T1.
  assign wait_expired_s = (state_r == T1) && !mem_ready &&
                          (wait_cnt_r == 5'(MEM_WAIT_MAX - 1));

  // Sticky timeout flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r | wait_expired_s;
    end
  end

  assign mem_timeout = timeout_r;
`else
  localparam int unused_wait_max = MEM_WAIT_MAX;
  assign wait_expired_s = 1'b0;
  assign mem_timeout    = 1'b0;
`endif

  // State register plus a marker for cycles after the first one in T1.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r   <= S_RST;
      t1_wait_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      t1_wait_r <= (state_r == T1) && (state_s == T1);
    end
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r | illegal_set_s;
    end
  end

  // Next-state decode; IR_Data is only consulted from T3 onward.
  always_comb begin
    state_s       = state_r;
    illegal_set_s = 1'b0;
    case (state_r)
      S_RST: state_s = T0;
      T0:    state_s = T1;
      T1: begin
        if (mem_ready) begin
          state_s = T2;
        end else if (wait_expired_s) begin
          state_s = S_HALT;
        end else begin
          state_s = T1;
        end
      end
      T2:    state_s = T3;
      T3: begin
        if (opcode_s == OP_NOP) begin
          state_s = T0;
        end else if (opcode_s == OP_HALT) begin
          state_s = S_HALT;
        end else if (!is_legal_s) begin
          state_s       = S_HALT;
          illegal_set_s = 1'b1;
        end else begin
          state_s = T4;
        end
      end
      T4:    state_s = T5;
      T5: begin
        if (is_muldiv_s) begin
          state_s = T6;
        end else begin
          state_s = T0;
        end
      end
      T6:     state_s = T0;
      S_HALT: state_s = S_HALT;
      default: state_s = S_RST;
    endcase
  end

  // Moore output decode; exactly one bus source is driven in T0-T6.
  always_comb begin
    gpr_enable      = 16'h0000;
    gpr_select      = 16'h0000;
    PC_enable       = 1'b0;
    IR_enable       = 1'b0;
    Y_enable        = 1'b0;
    Z_enable        = 1'b0;
    MAR_enable      = 1'b0;
    MDR_enable      = 1'b0;
    HI_enable       = 1'b0;
    LO_enable       = 1'b0;
    PC_select       = 1'b0;
    MDR_out_select  = 1'b0;
    Z_HI_select     = 1'b0;
    Z_LO_select     = 1'b0;
    MDR_read        = 1'b0;
    mem_read        = 1'b0;
    alu_instruction = 5'h00;
    halted          = 1'b0;
    case (state_r)
      T0: begin
        PC_select       = 1'b1;
        MAR_enable      = 1'b1;
        Z_enable        = 1'b1;
        alu_instruction = 5'h1F;
      end
      T1: begin
        Z_LO_select = 1'b1;
        PC_enable   = !t1_wait_r;
        mem_read    = 1'b1;
        MDR_read    = 1'b1;
        MDR_enable  = mem_ready;
      end
      T2: begin
        MDR_out_select = 1'b1;
        IR_enable      = 1'b1;
      end
      T3: begin
        gpr_select = reg_onehot(rb_s);
        Y_enable   = 1'b1;
      end
      T4: begin
        if (is_unary_s) begin
          gpr_select = reg_onehot(rb_s);
        end else begin
          gpr_select = reg_onehot(rc_s);
        end
        Z_enable        = 1'b1;
        alu_instruction = opcode_s;
      end
      T5: begin
        Z_LO_select = 1'b1;
        if (is_muldiv_s) begin
          LO_enable = 1'b1;
        end else begin
          gpr_enable = reg_onehot(ra_s);
        end
      end
      T6: begin
        Z_HI_select = 1'b1;
        HI_enable   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: begin
      end
    endcase
  end

  assign illegal_op = illegal_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. Stimulus pushes the hand-derived
// output vector for each cycle; a monitor pops and compares on the falling edge.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] gpr_en;
    logic [15:0] gpr_sel;
    logic        pc_en, ir_en, y_en, z_en, mar_en, mdr_en, hi_en, lo_en;
    logic        pc_sel, mdr_sel, zhi_sel, zlo_sel;
    logic        mdr_read, mem_read;
    logic [4:0]  alu;
    logic        halted, illegal, timeout;
  } out_t;

  logic        clk;
  logic        clr;
  logic [31:0] IR_Data;
  logic        mem_ready;
  logic [15:0] gpr_enable, gpr_select;
  logic        PC_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic        HI_enable, LO_enable, PC_select, MDR_out_select, Z_HI_select;
  logic        Z_LO_select, MDR_read, mem_read, halted, illegal_op, mem_timeout;
  logic [4:0]  alu_instruction;
  out_t        act;

  out_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  control_sequencer #(.MEM_WAIT_MAX(16)) dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .mem_ready(mem_ready),
    .gpr_enable(gpr_enable), .gpr_select(gpr_select),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
    .Z_enable(Z_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .PC_select(PC_select),
    .MDR_out_select(MDR_out_select), .Z_HI_select(Z_HI_select),
    .Z_LO_select(Z_LO_select), .MDR_read(MDR_read), .mem_read(mem_read),
    .alu_instruction(alu_instruction), .halted(halted),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  assign act = {gpr_enable, gpr_select, PC_enable, IR_enable, Y_enable, Z_enable,
                MAR_enable, MDR_enable, HI_enable, LO_enable, PC_select,
                MDR_out_select, Z_HI_select, Z_LO_select, MDR_read, mem_read,
                alu_instruction, halted, illegal_op, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", n, act, e);
      end
    end
  end

  function automatic out_t v_zero();
    out_t v;
    v = '0;
    return v;
  endfunction

  function automatic out_t v_t0();
    out_t v;
    v = '0;
    v.pc_sel = 1'b1; v.mar_en = 1'b1; v.z_en = 1'b1; v.alu = 5'h1F;
    return v;
  endfunction

  function automatic out_t v_t1(input logic first, input logic rdy);
    out_t v;
    v = '0;
    v.zlo_sel = 1'b1; v.pc_en = first; v.mem_read = 1'b1;
    v.mdr_read = 1'b1; v.mdr_en = rdy;
    return v;
  endfunction

  function automatic out_t v_t2();
    out_t v;
    v = '0;
    v.mdr_sel = 1'b1; v.ir_en = 1'b1;
    return v;
  endfunction

  function automatic out_t v_t3(input logic [15:0] sel);
    out_t v;
    v = '0;
    v.gpr_sel = sel; v.y_en = 1'b1;
    return v;
  endfunction

  function automatic out_t v_t4(input logic [15:0] sel, input logic [4:0] op);
    out_t v;
    v = '0;
    v.gpr_sel = sel; v.z_en = 1'b1; v.alu = op;
    return v;
  endfunction

  function automatic out_t v_t5(input logic [15:0] en, input logic lo);
    out_t v;
    v = '0;
    v.zlo_sel = 1'b1; v.gpr_en = en; v.lo_en = lo;
    return v;
  endfunction

  function automatic out_t v_t6();
    out_t v;
    v = '0;
    v.zhi_sel = 1'b1; v.hi_en = 1'b1;
    return v;
  endfunction

  function automatic out_t v_halt(input logic ill, input logic to);
    out_t v;
    v = '0;
    v.halted = 1'b1; v.illegal = ill; v.timeout = to;
    return v;
  endfunction

  task automatic step(input logic mr, input out_t v, input string nm);
    @(posedge clk);
    #1;
    mem_ready = mr;
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // clr dropped mid-cycle must zero everything before the next edge.
  task automatic pulse_clr(input string nm);
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_q.push_back(v_zero());
    name_q.push_back({nm, "_async"});
    @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.push_back(v_zero());
    name_q.push_back({nm, "_release"});
  endtask

  task automatic fetch(input logic [31:0] ir, input int waits, input string nm);
    step(1'b1, v_t0(), {nm, "_t0"});
    for (int i = 0; i < waits; i++) step(1'b0, v_t1(i == 0, 1'b0), {nm, "_t1_wait"});
    step(1'b1, v_t1(waits == 0, 1'b1), {nm, "_t1_ready"});
    IR_Data = ir;
    step(1'b0, v_t2(), {nm, "_t2"});
  endtask

  task automatic run_alu(input logic [31:0] ir, input int waits, input logic [15:0] s3,
                         input logic [15:0] s4, input logic [4:0] op,
                         input logic [15:0] wr, input string nm);
    fetch(ir, waits, nm);
    step(1'b1, v_t3(s3), {nm, "_t3"});
    step(1'b0, v_t4(s4, op), {nm, "_t4"});
    step(1'b1, v_t5(wr, 1'b0), {nm, "_t5"});
  endtask

  task automatic run_muldiv(input logic [31:0] ir, input int waits, input logic [15:0] s3,
                            input logic [15:0] s4, input logic [4:0] op, input string nm);
    fetch(ir, waits, nm);
    step(1'b1, v_t3(s3), {nm, "_t3"});
    step(1'b1, v_t4(s4, op), {nm, "_t4"});
    step(1'b1, v_t5(16'h0000, 1'b1), {nm, "_t5"});
    step(1'b1, v_t6(), {nm, "_t6"});
  endtask

  initial begin
    clr       = 1'b0;
    mem_ready = 1'b1;
    IR_Data   = 32'h0000_0000;

    repeat (3) step(1'b1, v_zero(), "reset_hold");
    @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.push_back(v_zero());
    name_q.push_back("reset_release");

    // add r3, r1, r2
    run_alu(32'h0189_0000, 0, 16'h0002, 16'h0004, 5'h00, 16'h0008, "add");
    // mul r1, r2 -> LO then HI
    run_muldiv(32'h4809_0000, 0, 16'h0002, 16'h0004, 5'h09, "mul");
    // neg r5, r7 (Rc=9 must be ignored) with three wait cycles in T1
    run_alu(32'h5ABC_8000, 3, 16'h0080, 16'h0080, 5'h0B, 16'h0020, "neg_wait");
    // sub r0, r15, r14: r0 writes like any other register
    run_alu(32'h087F_0000, 0, 16'h8000, 16'h4000, 5'h01, 16'h0001, "sub_r0");
    // div r3, r4 with one wait cycle
    run_muldiv(32'h501A_0000, 1, 16'h0008, 16'h0010, 5'h0A, "div");
    // nop: T3 straight back to T0
    fetch(32'hC000_0000, 0, "nop");
    step(1'b1, v_t3(16'h0001), "nop_t3");
    // halt
    fetch(32'hC800_0000, 0, "halt");
    step(1'b1, v_t3(16'h0001), "halt_t3");
    repeat (3) step(1'b1, v_halt(1'b0, 1'b0), "halt_stay");
    pulse_clr("clr_halt");

    // illegal opcode 0x1E
    fetch(32'hF000_0000, 0, "illegal");
    step(1'b1, v_t3(16'h0001), "illegal_t3");
    repeat (2) step(1'b1, v_halt(1'b1, 1'b0), "illegal_halt");
    pulse_clr("clr_illegal");

    // restart fetch, then abort in T4
    fetch(32'h0189_0000, 0, "abort");
    step(1'b1, v_t3(16'h0002), "abort_t3");
    pulse_clr("clr_mid_t4");
    step(1'b1, v_t0(), "refetch_t0");

`ifdef CU_MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step(1'b0, v_t1(i == 0, 1'b0), "timeout_t1");
    repeat (2) step(1'b0, v_halt(1'b0, 1'b1), "timeout_halt");
`endif

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
